// File: rtl/relay_pkg.sv
// Shared types and helpers for the relay instruction sequencer.
package relay_pkg;

   localparam int SEQ_STATES = 24;
   localparam int STATE_W    = 5;

   typedef logic [STATE_W-1:0] seq_state_t;

   typedef enum logic [2:0] {
      AB_24 = 3'd0,
      AB_8  = 3'd1,
      AB_10 = 3'd2,
      AB_12 = 3'd3,
      AB_14 = 3'd4
   } abort_e;

   typedef enum logic {
      PH_IDLE   = 1'b0,
      PH_ACTIVE = 1'b1
   } phase_e;

   // Undefined abort codes fall back to the full-length instruction.
   function automatic seq_state_t abort_len(input abort_e sel);
      seq_state_t len_s;
      case (sel)
         AB_8:    len_s = 5'd8;
         AB_10:   len_s = 5'd10;
         AB_12:   len_s = 5'd12;
         AB_14:   len_s = 5'd14;
         default: len_s = 5'd24;
      endcase
      return len_s;
   endfunction

   function automatic logic [SEQ_STATES-1:0] state_onehot(input seq_state_t s);
      logic [SEQ_STATES-1:0] oh_s;
      for (int i = 0; i < SEQ_STATES; i++) begin
         oh_s[i] = (s == STATE_W'(i + 1));
      end
      return oh_s;
   endfunction

endpackage

// File: rtl/relay_sequencer_if.sv
// Control and status bundle between the sequencer and the instruction decoder.
interface relay_sequencer_if;
   import relay_pkg::*;

   logic                  run;
   logic                  step;
   logic                  halt_req;
   logic [2:0]            abort_sel;
   seq_state_t            fsm_state;
   logic [SEQ_STATES-1:0] fsm_onehot;
   logic                  running;
   logic                  halted;
   logic                  inst_start;
   logic                  inst_done;

   modport master (
      output run, step, halt_req, abort_sel,
      input  fsm_state, fsm_onehot, running, halted, inst_start, inst_done
   );

   modport slave (
      input  run, step, halt_req, abort_sel,
      output fsm_state, fsm_onehot, running, halted, inst_start, inst_done
   );
endinterface

// File: rtl/seq_prescaler.sv
// Divides the clock into sequencer ticks; one tick every CLK_DIV enabled cycles.
module seq_prescaler #(
   parameter int CLK_DIV = 1
) (
   input  logic clock,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic tick
);
   localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CNT_W-1:0] count_r;

   assign tick = en && (count_r == CNT_W'(CLK_DIV - 1));

   // Cycle counter within the current sequencer state
   always_ff @(posedge clock) begin
      if (reset) begin
         count_r <= {CNT_W{1'b0}};
      end else if (clr || tick) begin
         count_r <= {CNT_W{1'b0}};
      end else if (en) begin
         count_r <= count_r + CNT_W'(1);
      end else begin
         count_r <= count_r;
      end
   end
endmodule

// File: rtl/relay_sequencer.sv
// Instruction-cycle sequencer: walks states 1..24 (or a shorter abort length) under run/step/halt.
module relay_sequencer
   import relay_pkg::*;
#(
   parameter int CLK_DIV = 1
) (
   input  logic             clock,
   input  logic             reset,
   relay_sequencer_if.slave bus
);
   phase_e                phase_r, phase_nx_s;
   seq_state_t            state_r, state_nx_s, len_s, end_n_s;
   logic [SEQ_STATES-1:0] onehot_r;
   logic                  halted_r, halted_nx_s;
   logic                  halt_q_r, halt_nx_s;
   logic                  run_q_r;
   logic                  inst_start_r, inst_start_nx_s;
   logic                  tick_s, start_s, last_s, clr_s, en_s;

   assign en_s  = (phase_r == PH_ACTIVE);
   assign clr_s = (phase_r != phase_nx_s);

   seq_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
      .clock (clock),
      .reset (reset),
      .clr   (clr_s),
      .en    (en_s),
      .tick  (tick_s)
   );

   // Instruction length; an abort shorter than the current state is a decoder error and runs full length
   always_comb begin
      len_s = abort_len(abort_e'(bus.abort_sel));
      if (state_r > len_s) begin
         end_n_s = STATE_W'(SEQ_STATES);
      end else begin
         end_n_s = len_s;
      end
   end

   // Next state, halt latch and halted flag
   always_comb begin
      phase_nx_s  = phase_r;
      state_nx_s  = state_r;
      halted_nx_s = halted_r;
      halt_nx_s   = halt_q_r;
      start_s     = 1'b0;
      last_s      = 1'b0;
      case (phase_r)
         PH_IDLE: begin
            halt_nx_s = 1'b0;
            start_s   = bus.step | (bus.run & ~halted_r) | (bus.run & ~run_q_r);
            if (start_s) begin
               phase_nx_s  = PH_ACTIVE;
               state_nx_s  = 5'd1;
               halted_nx_s = 1'b0;
            end else begin
               state_nx_s = 5'd0;
            end
         end
         PH_ACTIVE: begin
            halt_nx_s = halt_q_r | bus.halt_req;
            if (tick_s && (state_r == end_n_s)) begin
               last_s = 1'b1;
               if (halt_nx_s) begin
                  phase_nx_s  = PH_IDLE;
                  state_nx_s  = 5'd0;
                  halted_nx_s = 1'b1;
                  halt_nx_s   = 1'b0;
               end else if (!bus.run) begin
                  phase_nx_s = PH_IDLE;
                  state_nx_s = 5'd0;
               end else begin
                  state_nx_s = 5'd1;
               end
            end else if (tick_s) begin
               state_nx_s = state_r + 5'd1;
            end else begin
               state_nx_s = state_r;
            end
         end
         default: begin
            phase_nx_s = PH_IDLE;
            state_nx_s = 5'd0;
            halt_nx_s  = 1'b0;
         end
      endcase
      inst_start_nx_s = (state_nx_s == 5'd1) && (state_r != 5'd1);
   end

   // Sequencer registers; one-hot is registered in parallel with the binary state
   always_ff @(posedge clock) begin
      if (reset) begin
         phase_r      <= PH_IDLE;
         state_r      <= 5'd0;
         onehot_r     <= {SEQ_STATES{1'b0}};
         halted_r     <= 1'b0;
         halt_q_r     <= 1'b0;
         run_q_r      <= 1'b0;
         inst_start_r <= 1'b0;
      end else begin
         phase_r      <= phase_nx_s;
         state_r      <= state_nx_s;
         onehot_r     <= state_onehot(state_nx_s);
         halted_r     <= halted_nx_s;
         halt_q_r     <= halt_nx_s;
         run_q_r      <= bus.run;
         inst_start_r <= inst_start_nx_s;
      end
   end

   assign bus.fsm_state  = state_r;
   assign bus.fsm_onehot = onehot_r;
   assign bus.running    = (phase_r == PH_ACTIVE);
   assign bus.halted     = halted_r;
   assign bus.inst_start = inst_start_r;
   assign bus.inst_done  = last_s;
endmodule
